prefix_carry_pipe: RTL and testbench
====================================

Name: prefix_carry_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational carry-generation tree.
- Computes every bit-position carry of a WIDTH-bit addition from per-bit generate/propagate pairs plus carry-in, using a Kogge-Stone prefix network of log2(WIDTH) levels.
- Pipeline registers sit after selectable levels; valid/ready handshake with full backpressure.
- Sits between the operand-decode stage and the sum/compare stage of the score datapath.

Parameters:
- WIDTH, 32: number of bit positions; power of two, 4..128.
- LEVELS, $clog2(WIDTH): prefix levels; derived, never overridden.
- STAGE_MASK, 'b10100 (LEVELS bits): bit k set means a register follows prefix level k+1.
- TAG_W, 4: width of the sideband tag carried alongside each transaction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in_g  in  WIDTH  per-bit generate (a&b).
- in_p  in  WIDTH  per-bit propagate (a^b).
- in_cin  in  1  carry-in to bit 0.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_carry  out  WIDTH  out_carry[i] = carry out of bit i; out_carry[WIDTH-1] = carry-out.
- out_tag  out  TAG_W  tag matching out_carry.

Behaviour:
- Level-0 prefix pairs: bit 0 is folded with cin as G0 = g0 | (p0 & cin) and P0 = 0; all other bits use (g_i, p_i).
- Combine operator for a higher pair H and a lower pair L: G = Gh | (Ph & Gl); P = Ph & Pl.
- At level k, bit i combines with bit i - 2^(k-1) when i >= 2^(k-1); otherwise the pair passes through unchanged.
- out_carry[i] is the final G of bit i.
- Latency: S = popcount(STAGE_MASK) cycles from an accepted input to out_valid. With S = 0 the block is purely combinational: out_valid = in_valid and in_ready = out_ready.
- Each register stage holds a valid bit, a G/P vector and a tag.
- A stage loads when it is empty or when its downstream stage is also advancing. in_ready is the first stage's load condition, i.e. a standard elastic pipeline with a bubble-collapsing ready chain.
- in_ready may depend combinationally on out_ready. No skid buffer is used.
- A transfer occurs on any edge where valid and ready are both 1.
- While out_valid = 1 and out_ready = 0, out_carry and out_tag hold stable. No transaction is dropped, duplicated or reordered.
- Simultaneous accept and emit when full: the throughput of one transaction per cycle is sustained.
- Reset: every stage valid bit is cleared, so out_valid = 0. in_ready = 1 (for S > 0). Data registers reset to 0, so out_carry = 0 and out_tag = 0.
- Reset mid-operation: all in-flight transactions are discarded. The first accepted input after reset deasserts appears after exactly S cycles.
- Data registers load only when the stage loads; gating on valid is not required for correctness.

Optional Feature:
- Macro: PREFIX_GROUP_OUT_EN.
- When defined:
  - Extra output port out_grp_p (1 bit) = AND of all in_p, meaning the whole word propagates. It is pipelined alongside the tag.
  - Extra output port out_grp_g (1 bit) = carry-out computed with cin forced to 0.
  - These two ports let the upper word of a cascaded wide adder be fed.
- When undefined: neither port exists and no extra registers are inferred.

Decomposition:
- Shared package prefix_pkg holds:
  - the gp_t struct (g and p bits);
  - the function gp_combine(hi, lo);
  - the function stage_count(mask), a popcount used for latency checks;
  - the constant MAX_WIDTH = 128.
- One sub-module, prefix_level, implements a single combinational Kogge-Stone level. It is parametrised by WIDTH and DIST and instantiated LEVELS times in a generate loop. Each instance is followed by an optional register stage selected by STAGE_MASK.

Test Plan:
- WIDTH=8, S=2, out_ready=1: g=0x01, p=0xFE, cin=0 (0xFF+0x01) -> out_carry=0xFF two cycles later, tag echoed.
- g=0x00, p=0xFF, cin=1 -> out_carry=0xFF. Same input with cin=0 -> out_carry=0x00.
- Back-to-back stream of 16 random transactions with out_ready=1 -> one result per cycle. Each result matches a ripple-carry reference model, and tags appear in order 0..15.
- out_ready held at 0 for 5 cycles while driving inputs -> pipeline fills, in_ready drops after S accepts, and out_carry/out_tag stay stable. On release all S results drain in order with no loss.
- Assert rst for one cycle with 2 transactions in flight -> out_valid=0 and out_carry=0 immediately. The next input (g=0x80, p=0, cin=0) yields out_carry=0x80 after S cycles.
- STAGE_MASK=0 -> same-cycle result. With PREFIX_GROUP_OUT_EN defined and p=0xFF, g=0 -> out_grp_p=1, out_grp_g=0.

Source files
------------

// File: rtl/prefix_pkg.sv
// ----------------------------------------------------------------------------
// prefix_pkg
// Shared types and helpers for the Kogge-Stone carry prefix pipeline.
//   gp_t        : one generate/propagate pair
//   gp_combine  : prefix operator, higher pair absorbs lower pair
//   stage_count : popcount of a stage mask (pipeline latency in cycles)
//   MAX_WIDTH   : largest supported word width
// ----------------------------------------------------------------------------
package prefix_pkg;

  localparam int MAX_WIDTH = 128;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // The higher group generates if it generates on its own or if it
  // propagates a carry generated by the lower group.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t res;
    res.g = hi.g | (hi.p & lo.g);
    res.p = hi.p & lo.p;
    return res;
  endfunction

  // Number of register stages selected by a mask.
  function automatic int stage_count(input logic [31:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/prefix_carry_pipe_if.sv
// ----------------------------------------------------------------------------
// prefix_carry_pipe_if
// Handshake bundle for prefix_carry_pipe.
//   Input side : in_valid, in_ready, in_g, in_p, in_cin, in_tag
//   Output side: out_valid, out_ready, out_carry, out_tag
//   With PREFIX_GROUP_OUT_EN: out_grp_p, out_grp_g (group propagate/generate)
// Modports: slave = the carry pipe, master = the producer/consumer around it.
// ----------------------------------------------------------------------------
interface prefix_carry_pipe_if
  import prefix_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_g;
  logic [WIDTH-1:0] in_p;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_carry;
  logic [TAG_W-1:0] out_tag;
`ifdef PREFIX_GROUP_OUT_EN
  logic             out_grp_p;
  logic             out_grp_g;

  modport slave (
    input  in_valid, in_g, in_p, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_carry, out_tag, out_grp_p, out_grp_g
  );

  modport master (
    output in_valid, in_g, in_p, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_carry, out_tag, out_grp_p, out_grp_g
  );
`else
  modport slave (
    input  in_valid, in_g, in_p, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_carry, out_tag
  );

  modport master (
    output in_valid, in_g, in_p, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_carry, out_tag
  );
`endif

endinterface

// File: rtl/prefix_level.sv
// ----------------------------------------------------------------------------
// prefix_level
// One combinational Kogge-Stone level: bit i absorbs bit i-DIST, bits below
// DIST pass through untouched.
//   i_pairs : WIDTH generate/propagate pairs entering the level
//   o_pairs : WIDTH pairs leaving the level
// ----------------------------------------------------------------------------
module prefix_level
  import prefix_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  gp_t [WIDTH-1:0] i_pairs,
  output gp_t [WIDTH-1:0] o_pairs
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign o_pairs[i] = gp_combine(i_pairs[i], i_pairs[i-DIST]);
    end else begin : g_pass
      assign o_pairs[i] = i_pairs[i];
    end
  end

endmodule

// File: rtl/prefix_carry_pipe.sv
// ----------------------------------------------------------------------------
// prefix_carry_pipe
// Pipelined Kogge-Stone carry network. Produces the carry out of every bit
// position from per-bit generate/propagate plus carry-in. A register stage
// follows prefix level k+1 when STAGE_MASK[k] is set; latency equals
// popcount(STAGE_MASK). Elastic valid/ready pipeline, full backpressure.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : prefix_carry_pipe_if.slave (input and output handshakes)
// Optional macro PREFIX_GROUP_OUT_EN adds out_grp_p / out_grp_g, pipelined
// next to the tag.
// ----------------------------------------------------------------------------
module prefix_carry_pipe
  import prefix_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int LEVELS = $clog2(WIDTH),
  parameter logic [LEVELS-1:0] STAGE_MASK = 'b10100,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  prefix_carry_pipe_if.slave bus
);

`ifdef PREFIX_GROUP_OUT_EN
  localparam int SIDE_W = TAG_W + 2;
`else
  localparam int SIDE_W = TAG_W;
`endif

  gp_t [WIDTH-1:0]   w_pairs0;
  logic [SIDE_W-1:0] w_side0;
  gp_t [WIDTH-1:0]   w_final;
  logic [SIDE_W-1:0] w_sideFinal;

  // Carry-in is folded into bit 0 so the network never needs it again; the
  // cleared propagate stops anything from being combined below bit 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_seed
    if (i == 0) begin : g_cin
      assign w_pairs0[i] = '{g: bus.in_g[0] | (bus.in_p[0] & bus.in_cin), p: 1'b0};
    end else begin : g_plain
      assign w_pairs0[i] = '{g: bus.in_g[i], p: bus.in_p[i]};
    end
  end

`ifdef PREFIX_GROUP_OUT_EN
  gp_t w_grpAcc;
  gp_t w_bitPair;

  // Whole-word group pair with carry-in ignored, for feeding the next word
  // of a cascaded adder.
  always_comb begin
    w_grpAcc  = '{g: 1'b0, p: 1'b1};
    w_bitPair = '{g: 1'b0, p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      w_bitPair.g = bus.in_g[i];
      w_bitPair.p = bus.in_p[i];
      w_grpAcc    = gp_combine(w_bitPair, w_grpAcc);
    end
  end

  assign w_side0 = {w_grpAcc.p, w_grpAcc.g, bus.in_tag};
`else
  assign w_side0 = bus.in_tag;
`endif

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    gp_t [WIDTH-1:0]   w_in;
    gp_t [WIDTH-1:0]   w_comb;
    gp_t [WIDTH-1:0]   w_out;
    logic [SIDE_W-1:0] w_sideIn;
    logic [SIDE_W-1:0] w_sideOut;
    logic              w_validIn;
    logic              w_validOut;
    logic              w_readyIn;
    logic              w_readyOut;

    if (k == 1) begin : g_first
      assign w_in      = w_pairs0;
      assign w_sideIn  = w_side0;
      assign w_validIn = bus.in_valid;
    end else begin : g_chain
      assign w_in      = g_lvl[k-1].w_out;
      assign w_sideIn  = g_lvl[k-1].w_sideOut;
      assign w_validIn = g_lvl[k-1].w_validOut;
    end

    if (k == LEVELS) begin : g_last
      assign w_readyOut = bus.out_ready;
    end else begin : g_mid
      assign w_readyOut = g_lvl[k+1].w_readyIn;
    end

    prefix_level #(
      .WIDTH(WIDTH),
      .DIST (1 << (k - 1))
    ) u_level (
      .i_pairs(w_in),
      .o_pairs(w_comb)
    );

    if (STAGE_MASK[k-1]) begin : g_reg
      logic              r_valid;
      gp_t [WIDTH-1:0]   r_gp;
      logic [SIDE_W-1:0] r_side;
      logic              w_load;

      // A stage takes new data when empty or when its contents are leaving
      // on the same edge, so bubbles collapse and a full pipe still moves
      // one transaction per cycle.
      assign w_load = ~r_valid | w_readyOut;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_gp    <= '0;
          r_side  <= '0;
        end else if (w_load) begin
          r_valid <= w_validIn;
          r_gp    <= w_comb;
          r_side  <= w_sideIn;
        end
      end

      assign w_readyIn  = w_load;
      assign w_validOut = r_valid;
      assign w_out      = r_gp;
      assign w_sideOut  = r_side;
    end else begin : g_thru
      assign w_readyIn  = w_readyOut;
      assign w_validOut = w_validIn;
      assign w_out      = w_comb;
      assign w_sideOut  = w_sideIn;
    end
  end

  assign w_final       = g_lvl[LEVELS].w_out;
  assign w_sideFinal   = g_lvl[LEVELS].w_sideOut;
  assign bus.out_valid = g_lvl[LEVELS].w_validOut;
  assign bus.in_ready  = g_lvl[1].w_readyIn;
  assign bus.out_tag   = w_sideFinal[TAG_W-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign bus.out_carry[i] = w_final[i].g;
  end

`ifdef PREFIX_GROUP_OUT_EN
  assign bus.out_grp_g = w_sideFinal[TAG_W];
  assign bus.out_grp_p = w_sideFinal[TAG_W+1];
`endif

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// ----------------------------------------------------------------------------
// tb_prefix_carry_pipe
// Drives an 8-bit carry pipe with two register stages (mask 3'b101) and a
// purely combinational copy (mask 3'b000) side by side. Directed vectors
// with hand-computed carries, a random back-to-back stream scored against a
// ripple-carry model, a backpressure hold, and a mid-flight reset.
// ----------------------------------------------------------------------------
module tb_prefix_carry_pipe;
  import prefix_pkg::*;

  localparam int W     = 8;
  localparam int TW    = 4;
  localparam int S     = stage_count(32'b101);
  localparam int NVEC  = 7;

  typedef struct {
    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic          cin;
    logic [TW-1:0] tag;
    logic [W-1:0]  expCarry;
  } vec_t;

  logic clk;
  logic rst;

  int compared;
  int failed;
  int cycleCnt;
  int monCount;
  int firstCyc;
  int lastCyc;
  logic monEnable;

  logic [W-1:0]  expCarryQ[$];
  logic [TW-1:0] expTagQ[$];
  vec_t vecs[NVEC];

  prefix_carry_pipe_if #(.WIDTH(W), .TAG_W(TW)) busP ();
  prefix_carry_pipe_if #(.WIDTH(W), .TAG_W(TW)) busC ();

  prefix_carry_pipe #(
    .WIDTH     (W),
    .STAGE_MASK(3'b101),
    .TAG_W     (TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busP)
  );

  prefix_carry_pipe #(
    .WIDTH     (W),
    .STAGE_MASK(3'b000),
    .TAG_W     (TW)
  ) dutComb (
    .clk(clk),
    .rst(rst),
    .bus(busC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference: plain ripple carry, one bit at a time.
  function automatic logic [W-1:0] rippleCarry(input logic [W-1:0] g, input logic [W-1:0] p,
                                               input logic cin);
    logic [W-1:0] c;
    logic cy;
    cy = cin;
    for (int i = 0; i < W; i++) begin
      cy   = g[i] | (p[i] & cy);
      c[i] = cy;
    end
    return c;
  endfunction

  function automatic logic groupGen(input logic [W-1:0] g, input logic [W-1:0] p);
    logic [W-1:0] c;
    c = rippleCarry(g, p, 1'b0);
    return c[W-1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] g, input logic [W-1:0] p, input logic cin,
                               input logic [TW-1:0] tag, input logic valid);
    busP.in_g = g;  busP.in_p = p;  busP.in_cin = cin;  busP.in_tag = tag;  busP.in_valid = valid;
    busC.in_g = g;  busC.in_p = p;  busC.in_cin = cin;  busC.in_tag = tag;  busC.in_valid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the pipelined DUT: every transfer must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (monEnable && busP.out_valid && busP.out_ready) begin
      if (expCarryQ.size() == 0) begin
        checkOutput("unexpectedResult", expCarryQ.size(), 1);
      end else begin
        checkOutput("scoreCarry", busP.out_carry, expCarryQ.pop_front());
        checkOutput("scoreTag", busP.out_tag, expTagQ.pop_front());
      end
      if (monCount == 0) firstCyc = cycleCnt;
      lastCyc = cycleCnt;
      monCount++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] a, b, g, p, heldCarry;
    logic [TW-1:0] heldTag;
    logic cin, held;
    int acceptCnt;

    compared  = 0;
    failed    = 0;
    cycleCnt  = 0;
    monCount  = 0;
    firstCyc  = 0;
    lastCyc   = 0;
    monEnable = 1'b0;

    vecs[0] = '{g: 8'h01, p: 8'hFE, cin: 1'b0, tag: 4'h3, expCarry: 8'hFF};
    vecs[1] = '{g: 8'h00, p: 8'hFF, cin: 1'b1, tag: 4'h5, expCarry: 8'hFF};
    vecs[2] = '{g: 8'h00, p: 8'hFF, cin: 1'b0, tag: 4'hA, expCarry: 8'h00};
    vecs[3] = '{g: 8'h80, p: 8'h00, cin: 1'b0, tag: 4'h1, expCarry: 8'h80};
    vecs[4] = '{g: 8'h01, p: 8'h0E, cin: 1'b0, tag: 4'h7, expCarry: 8'h0F};
    vecs[5] = '{g: 8'h0C, p: 8'h33, cin: 1'b0, tag: 4'hC, expCarry: 8'h3C};
    vecs[6] = '{g: 8'h00, p: 8'h00, cin: 1'b1, tag: 4'hF, expCarry: 8'h00};

    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, '0, 1'b0);
    busP.out_ready = 1'b1;
    busC.out_ready = 1'b1;
    #3;
    checkOutput("resetOutValid", busP.out_valid, 0);
    checkOutput("resetOutCarry", busP.out_carry, 0);
    checkOutput("resetOutTag", busP.out_tag, 0);
    checkOutput("resetInReady", busP.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].g, vecs[v].p, vecs[v].cin, vecs[v].tag, 1'b1);
      #1;
      checkOutput("combValid", busC.out_valid, 1);
      checkOutput("combCarry", busC.out_carry, vecs[v].expCarry);
      checkOutput("combTag", busC.out_tag, vecs[v].tag);
      checkOutput("combReady", busC.in_ready, 1);
`ifdef PREFIX_GROUP_OUT_EN
      checkOutput("combGrpP", busC.out_grp_p, &vecs[v].p);
      checkOutput("combGrpG", busC.out_grp_g, groupGen(vecs[v].g, vecs[v].p));
`endif
      checkOutput("pipeInReady", busP.in_ready, 1);
      step();
      applyStimulus(vecs[v].g, vecs[v].p, vecs[v].cin, vecs[v].tag, 1'b0);
      checkOutput("pipeEarlyValid", busP.out_valid, 0);
      step();
      checkOutput("pipeValid", busP.out_valid, 1);
      checkOutput("pipeCarry", busP.out_carry, vecs[v].expCarry);
      checkOutput("pipeTag", busP.out_tag, vecs[v].tag);
`ifdef PREFIX_GROUP_OUT_EN
      checkOutput("pipeGrpP", busP.out_grp_p, &vecs[v].p);
      checkOutput("pipeGrpG", busP.out_grp_g, groupGen(vecs[v].g, vecs[v].p));
`endif
      step();
    end

    busC.out_ready = 1'b0;
    #1;
    checkOutput("combReadyFollows", busC.in_ready, 0);
    busC.out_ready = 1'b1;

    $display("[TB] back-to-back stream");
    monCount  = 0;
    monEnable = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      g   = a & b;
      p   = a ^ b;
      cin = 1'($urandom_range(0, 1));
      applyStimulus(g, p, cin, TW'(i), 1'b1);
      #1;
      checkOutput("streamInReady", busP.in_ready, 1);
      if (busP.in_ready) begin
        expCarryQ.push_back(rippleCarry(g, p, cin));
        expTagQ.push_back(TW'(i));
      end
      step();
    end
    applyStimulus('0, '0, 1'b0, '0, 1'b0);
    for (int t = 0; t < 20 && monCount < 16; t++) step();
    checkOutput("streamCount", monCount, 16);
    checkOutput("streamSpacing", lastCyc - firstCyc, 15);

    $display("[TB] backpressure hold");
    monCount       = 0;
    acceptCnt      = 0;
    held           = 1'b0;
    heldCarry      = '0;
    heldTag        = '0;
    busP.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      g   = a & b;
      p   = a ^ b;
      cin = 1'($urandom_range(0, 1));
      applyStimulus(g, p, cin, TW'(c + 8), 1'b1);
      #1;
      if (busP.in_ready) begin
        acceptCnt++;
        expCarryQ.push_back(rippleCarry(g, p, cin));
        expTagQ.push_back(TW'(c + 8));
      end
      if (busP.out_valid) begin
        if (!held) begin
          held      = 1'b1;
          heldCarry = busP.out_carry;
          heldTag   = busP.out_tag;
        end else begin
          checkOutput("holdCarry", busP.out_carry, heldCarry);
          checkOutput("holdTag", busP.out_tag, heldTag);
        end
      end
      step();
    end
    #1;
    checkOutput("holdAccepts", acceptCnt, S);
    checkOutput("holdInReady", busP.in_ready, 0);
    checkOutput("holdValid", busP.out_valid, 1);
    applyStimulus('0, '0, 1'b0, '0, 1'b0);
    busP.out_ready = 1'b1;
    for (int t = 0; t < 10 && monCount < acceptCnt; t++) step();
    checkOutput("drainCount", monCount, S);
    checkOutput("drainQueueEmpty", expCarryQ.size(), 0);

    $display("[TB] reset with transactions in flight");
    monEnable = 1'b0;
    expCarryQ.delete();
    expTagQ.delete();
    step();
    applyStimulus(8'h01, 8'hFE, 1'b0, 4'h2, 1'b1);
    step();
    applyStimulus(8'h0C, 8'h33, 1'b1, 4'h4, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0, '0, 1'b0);
    checkOutput("preResetValid", busP.out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midResetValid", busP.out_valid, 0);
    checkOutput("midResetCarry", busP.out_carry, 0);
    checkOutput("midResetTag", busP.out_tag, 0);
    checkOutput("midResetInReady", busP.in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(8'h80, 8'h00, 1'b0, 4'h9, 1'b1);
    #1;
    checkOutput("postResetInReady", busP.in_ready, 1);
    step();
    applyStimulus('0, '0, 1'b0, '0, 1'b0);
    checkOutput("postResetEarly", busP.out_valid, 0);
    step();
    checkOutput("postResetValid", busP.out_valid, 1);
    checkOutput("postResetCarry", busP.out_carry, 8'h80);
    checkOutput("postResetTag", busP.out_tag, 4'h9);
    step();
    checkOutput("postResetDrained", busP.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
